// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: arbiter state encoding, port indices, one-hot helper.
package cpu_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_DBG = 1'b1;

  // One-hot grant vector for a two-port arbiter.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the port that did not own last wins.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       owner,
  output logic       valid
);

  // Pick the single requester, or alternate on a tie.
  always_comb begin
    valid = |req;
    owner = ARB_PORT_CPU;
    if (req == 2'b11) begin
      owner = ~last_owner;
    end else if (req[ARB_PORT_DBG]) begin
      owner = ARB_PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory, with bounded bus lock.
// Optional per-port grant and conflict counters when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

  arb_state_e     state, state_d;
  logic           owner, owner_d;
  logic           last_owner, arb_last;
  logic [LCW-1:0] lock_cnt, lock_cnt_d;
  logic           access, stay;
  logic           pick_owner, pick_valid;

  // An access happens only while the owner still holds its request in GRANT.
  assign access   = (state == ARB_GRANT) && req[owner];
  assign stay     = access && lock[owner] && (lock_cnt < LCW'(MAX_LOCK - 1));
  assign arb_last = access ? owner : last_owner;

  rr_pick2 u_pick (
    .req        (req),
    .last_owner (arb_last),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  // State, owner, last owner and lock-length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= ARB_PORT_CPU;
      last_owner <= ARB_PORT_DBG;
      lock_cnt   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= arb_last;
      lock_cnt   <= lock_cnt_d;
    end
  end

  // Next state: hold ownership while locked, otherwise re-arbitrate in the same cycle.
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    lock_cnt_d = lock_cnt;
    case (state)
      ARB_IDLE: begin
        lock_cnt_d = '0;
        if (pick_valid) begin
          state_d = ARB_GRANT;
          owner_d = pick_owner;
        end
      end
      ARB_GRANT: begin
        if (stay) begin
          lock_cnt_d = lock_cnt + LCW'(1);
        end else begin
          lock_cnt_d = '0;
          if (pick_valid) begin
            state_d = ARB_GRANT;
            owner_d = pick_owner;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Memory-side mux; quiet outside an access so the memory sees no stray write.
  assign gnt       = access ? port_onehot(owner) : 2'b00;
  assign mem_we    = access && we[owner];
  assign mem_addr  = access ? ((owner == ARB_PORT_DBG) ? addr1 : addr0) : '0;
  assign mem_wdata = access ? ((owner == ARB_PORT_DBG) ? wdata1 : wdata0) : '0;

  // Read return register, valid one cycle after a read grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 2'b00;
      rdata  <= '0;
    end else begin
      rvalid <= 2'b00;
      if (access && !we[owner]) begin
        rvalid <= port_onehot(owner);
        rdata  <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating per-port grant counters and tie counter for arbitration cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt[ARB_PORT_CPU] && (gnt_cnt0 != 16'hFFFF)) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt[ARB_PORT_DBG] && (gnt_cnt1 != 16'hFFFF)) gnt_cnt1 <= gnt_cnt1 + 16'd1;
      if (!stay && (req == 2'b11) && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory.
// Build with DMEM_ARB_STATS_EN to also check the statistics counters.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] lock = 2'b00;
  logic [1:0] we = 2'b00;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  logic [7:0] mem [256];
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = 8'h00, pre_data = 8'h00;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  // Combinational-read, clocked-write memory with a bench preload port.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] t2_exp(input int i);
    if (i == 0) return 2'b00;
    return (i % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    logic [1:0] g;
    logic [1:0] e;
    int k;

    // Reset values
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);

    poke(8'h10, 8'hA5);
    poke(8'h11, 8'h3C);
    poke(8'h20, 8'h00);
    poke(8'h30, 8'h77);

    // 1: single read on port 0
    do_reset();
    req = 2'b01; we = 2'b00; addr0 = 8'h10;
    @(negedge clk);
    chk("t1_c1_gnt", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    chk("t1_c2_gnt", 32'(gnt), 32'h1);
    chk("t1_c2_addr", 32'(mem_addr), 32'h10);
    chk("t1_c2_we", 32'(mem_we), 32'h0);
    step();
    req = 2'b00;
    @(negedge clk);
    chk("t1_c3_rvalid", 32'(rvalid), 32'h1);
    chk("t1_c3_rdata", 32'(rdata), 32'hA5);
    chk("t1_c3_gnt", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    chk("t1_c4_rvalid", 32'(rvalid), 32'h0);

    // 2: simultaneous continuous reads alternate, port 0 first
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 8'h10; addr1 = 8'h11;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(t2_exp(i)));
      if (i >= 1) begin
        e = t2_exp(i - 1);
        chk($sformatf("t2_rvalid%0d", i), 32'(rvalid), 32'(e));
        if (i >= 2) chk($sformatf("t2_rdata%0d", i), 32'(rdata), (e == 2'b01) ? 32'hA5 : 32'h3C);
      end
      step();
    end
    req = 2'b00;
    @(negedge clk);
    chk("t2_tail_gnt", 32'(gnt), 32'h0);
`ifdef DMEM_ARB_STATS_EN
    chk("t6_gnt_cnt0", 32'(gnt_cnt0), 32'd5);
    chk("t6_gnt_cnt1", 32'(gnt_cnt1), 32'd5);
    chk("t6_conflict_ge1", 32'(conflict_cnt >= 16'd1), 32'h1);
`endif
    step();

    // 3: locked burst of 20 writes on port 1, port 0 waiting
    do_reset();
    req = 2'b10; lock = 2'b10; we = 2'b10; addr1 = 8'h40; wdata1 = 8'h00;
    k = 0;
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      g = gnt;
      if (c == 0) e = 2'b00;
      else if (c <= 16) e = 2'b10;
      else if (c == 17) e = 2'b01;
      else if (c <= 21) e = 2'b10;
      else e = 2'b00;
      chk($sformatf("t3_gnt%0d", c), 32'(g), 32'(e));
      if (c == 18) begin
        chk("t3_rvalid0", 32'(rvalid), 32'h1);
        chk("t3_rdata0", 32'(rdata), 32'hA5);
      end
      step();
      if (c == 0) begin
        req[0] = 1'b1; we[0] = 1'b0; addr0 = 8'h10;
      end
      if (g[1]) begin
        k++;
        if (k == 20) begin
          req[1] = 1'b0; lock[1] = 1'b0;
        end else begin
          addr1 = 8'(32'h40 + k); wdata1 = 8'(k);
        end
      end
      if (g[0]) req[0] = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t3_mem%0d", i), 32'(mem[8'h40 + 8'(i)]), 32'(i));
    end

    // 4: port 0 write then port 1 read of the same address
    do_reset();
    req = 2'b11; we = 2'b01; addr0 = 8'h20; wdata0 = 8'h55; addr1 = 8'h20;
    @(negedge clk);
    chk("t4_c0_gnt", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    chk("t4_c1_gnt", 32'(gnt), 32'h1);
    chk("t4_c1_we", 32'(mem_we), 32'h1);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t4_c2_gnt", 32'(gnt), 32'h2);
    chk("t4_c2_we", 32'(mem_we), 32'h0);
    step();
    req[1] = 1'b0;
    @(negedge clk);
    chk("t4_c3_rvalid", 32'(rvalid), 32'h2);
    chk("t4_c3_rdata", 32'(rdata), 32'h55);
    step();

    // 5: reset during a write grant aborts it
    do_reset();
    req = 2'b01; we = 2'b01; addr0 = 8'h30; wdata0 = 8'h99;
    step();
    @(negedge clk);
    chk("t5_pre_gnt", 32'(gnt), 32'h1);
    chk("t5_pre_we", 32'(mem_we), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_we", 32'(mem_we), 32'h0);
    chk("t5_rst_rvalid", 32'(rvalid), 32'h0);
    step();
    req = 2'b00; we = 2'b00;
    rst = 1'b0;
    step();
    chk("t5_mem_kept", 32'(mem[8'h30]), 32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
